// File: rtl/ps2_rx_pkg.sv
// ps2_pkg: shared state type and defaults for the PS/2 receiver
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
  localparam int PS2_DATA_BITS = 8;
  localparam int FILTER_LEN_DEF = 8;
  localparam int TIMEOUT_CYCLES_DEF = 100000;
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchroniser, run-length deglitch filter and falling-edge detect
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic fall
);
  logic [1:0] sync;
  logic [7:0] run;
  // run counts consecutive synchronised samples that disagree with the filtered level
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync  <= 2'b11;
      run   <= '0;
      level <= 1'b1;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], pin};
      fall <= 1'b0;
      if (sync[1] == level) run <= '0;
      else if (run == 8'(FILTER_LEN - 1)) begin
        run   <= '0;
        level <= sync[1];
        fall  <= level;
      end else run <= run + 8'd1;
    end
endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver with parity, stop-bit and timeout checking
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       app_clk,
  input  logic       app_arst,
  input  logic       enable,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       busy
);
  ps2_state_t state, state_n;
  logic [1:0] data_sync;
  logic [7:0] shreg, shreg_n, rx_data_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [19:0] tmo, tmo_n;
  logic par, par_n, valid_n, perr_n, ferr_n;
  logic clk_level, clk_fall, fall, din;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk  (app_clk),
    .rst  (app_arst),
    .pin  (ps2_clk),
    .level(clk_level),
    .fall (clk_fall)
  );

  // a genuine fall always coincides with the filtered level having just gone low
  assign fall = clk_fall & ~clk_level;
  assign din  = data_sync[1];
  assign busy = state != IDLE;

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    par_n     = par;
    rx_data_n = rx_data;
    valid_n   = 1'b0;
    perr_n    = 1'b0;
    ferr_n    = 1'b0;
    tmo_n     = (state == IDLE || fall) ? '0 : tmo + 20'd1;
    if (!enable) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      tmo_n     = '0;
    end else if (fall) begin
      case (state)
        IDLE: if (!din) begin
          shreg_n   = '0;
          bit_cnt_n = '0;
          state_n   = DATA;
        end
        DATA: begin
          shreg_n   = {din, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          state_n   = (bit_cnt == 3'(PS2_DATA_BITS - 1)) ? PARITY : DATA;
        end
        PARITY: begin
          par_n   = din;
          state_n = STOP;
        end
        STOP: begin
          state_n   = IDLE;
          ferr_n    = !din;
          valid_n   = din && (^{shreg, par});
          perr_n    = din && !(^{shreg, par});
          rx_data_n = valid_n ? shreg : rx_data;
        end
      endcase
    end else if (state != IDLE && tmo == 20'(TIMEOUT_CYCLES - 1)) begin
      ferr_n  = 1'b1;
      state_n = IDLE;
      tmo_n   = '0;
    end
  end

  always_ff @(posedge app_clk or posedge app_arst)
    if (app_arst) begin
      data_sync     <= 2'b11;
      state         <= IDLE;
      shreg         <= '0;
      bit_cnt       <= '0;
      par           <= 1'b0;
      tmo           <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      data_sync     <= {data_sync[0], ps2_data};
      state         <= state_n;
      shreg         <= shreg_n;
      bit_cnt       <= bit_cnt_n;
      par           <= par_n;
      tmo           <= tmo_n;
      rx_data       <= rx_data_n;
      rx_valid      <= valid_n;
      rx_parity_err <= perr_n;
      rx_frame_err  <= ferr_n;
    end
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: scoreboard bench driving PS/2 frames into ps2_rx and checking result pulses
module tb_ps2_rx;
  localparam int FLEN = 8;
  localparam int TMO = 300;
  localparam int HALF = 40;
  localparam int K_VALID = 0, K_PERR = 1, K_FERR = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  logic app_clk = 0, app_arst = 1, enable = 1, ps2_clk = 1, ps2_data = 1;
  logic [7:0] rx_data;
  logic rx_valid, rx_parity_err, rx_frame_err, busy;
  int checks = 0, errors = 0, cyc = 0, last_fall = 0, last_pulse = 0, mk;
  exp_t q[$];
  exp_t e;

  ps2_rx #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO)) dut (
    .app_clk      (app_clk),
    .app_arst     (app_arst),
    .enable       (enable),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err (rx_frame_err),
    .busy         (busy)
  );

  always #5 app_clk = ~app_clk;
  always @(posedge app_clk) cyc <= cyc + 1;

  always @(negedge app_clk)
    if (!app_arst && (rx_valid || rx_parity_err || rx_frame_err)) begin
      mk = rx_valid ? K_VALID : rx_parity_err ? K_PERR : K_FERR;
      last_pulse = cyc;
      checks++;
      if ($countones({rx_valid, rx_parity_err, rx_frame_err}) != 1) begin
        errors++;
        $display("FAIL onehot pulses=%b required one", {rx_valid, rx_parity_err, rx_frame_err});
      end else if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse kind=%0d data=%02h", mk, rx_data);
      end else begin
        e = q.pop_front();
        if (e.kind != mk || rx_data !== e.data) begin
          errors++;
          $display("FAIL pulse kind=%0d data=%02h required kind=%0d data=%02h", mk, rx_data, e.kind, e.data);
        end
      end
    end

  task automatic tick(input int n);
    repeat (n) @(posedge app_clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] data);
    exp_t x;
    x.kind = kind;
    x.data = data;
    q.push_back(x);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    tick(HALF);
    ps2_clk = 0;
    last_fall = cyc;
    tick(HALF);
    ps2_clk = 1;
  endtask

  task automatic glitch();
    ps2_clk = 0;
    tick(3);
    ps2_clk = 1;
    tick(HALF);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int nbits, input int glitch_at);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      if (i == glitch_at) glitch();
      send_bit(f[i]);
    end
    ps2_data = 1;
    tick(HALF);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      tick(1);
      n++;
    end
    chk({name, "_drain"}, q.size(), 0);
    tick(5);
  endtask

  initial begin
    tick(3);
    chk("reset_data", rx_data, 8'h00);
    chk("reset_valid", rx_valid, 0);
    chk("reset_perr", rx_parity_err, 0);
    chk("reset_ferr", rx_frame_err, 0);
    chk("reset_busy", busy, 0);
    app_arst = 0;
    tick(20);

    expect_ev(K_VALID, 8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    drain("good_1c");
    chk("busy_after_good", busy, 0);
    chk("data_1c", rx_data, 8'h1C);

    expect_ev(K_PERR, 8'h1C);
    send_frame(8'h1C, 1'b1, 1'b1, 11, -1);
    drain("parity_err");

    expect_ev(K_FERR, 8'h1C);
    send_frame(8'h55, 1'b0, 1'b0, 11, -1);
    drain("stop_err");

    expect_ev(K_FERR, 8'h1C);
    send_frame(8'h33, 1'b0, 1'b1, 6, -1);
    drain("timeout");
    checks++;
    if (last_pulse - last_fall - (FLEN + 2) < TMO - 1 || last_pulse - last_fall - (FLEN + 2) > TMO + 1) begin
      errors++;
      $display("FAIL timeout_delay actual=%0d required=%0d+-1", last_pulse - last_fall - (FLEN + 2), TMO);
    end
    chk("busy_after_timeout", busy, 0);

    expect_ev(K_VALID, 8'hF0);
    send_frame(8'hF0, 1'b1, 1'b1, 11, -1);
    drain("good_f0");

    glitch();
    chk("glitch_idle_busy", busy, 0);
    expect_ev(K_VALID, 8'h5A);
    send_frame(8'h5A, 1'b1, 1'b1, 11, 4);
    drain("glitch_5a");

    send_frame(8'h77, 1'b0, 1'b1, 5, -1);
    chk("busy_midframe", busy, 1);
    enable = 0;
    tick(3);
    chk("busy_disabled", busy, 0);
    tick(TMO + 50);
    enable = 1;
    tick(20);
    expect_ev(K_VALID, 8'h29);
    send_frame(8'h29, 1'b0, 1'b1, 11, -1);
    drain("reenable_29");

    send_frame(8'h1C, 1'b0, 1'b1, 4, -1);
    chk("busy_before_arst", busy, 1);
    app_arst = 1;
    #1;
    chk("arst_data", rx_data, 8'h00);
    chk("arst_busy", busy, 0);
    chk("arst_pulses", {rx_valid, rx_parity_err, rx_frame_err}, 0);
    tick(3);
    app_arst = 0;
    tick(20);
    expect_ev(K_VALID, 8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    drain("after_arst");
    chk("final_queue", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
